// File: rtl/simplez_io.sv
// rtl/simplez_io.sv - Simplez memory-mapped screen/keyboard responder (8N1 UART at words 508-511)
module simplez_io #(
    parameter int BAUD_DIV = 104,
    parameter int AW       = 9,
    parameter int DW       = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic          rw,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    output logic          io_sel,
    output logic          tx,
    input  logic          rx
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    tx_state_t     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_q, tx_d;

    logic [1:0]    rx_sync_q;
    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_ready_q, rx_ready_d;
    logic          overrun_q, overrun_d;

    logic [DW-1:0] data_out_q, data_out_d;
    logic          io_sel_q, io_sel_d;

    logic io_hit, rd_en, tx_wr, tx_ready, rx_s, rx_latch;
    logic unused_data_hi;
    assign unused_data_hi = ^data_in[DW-1:8];

    always_comb begin
        io_hit     = (addr[AW-1:2] == '1);
        rd_en      = rw && io_hit;
        tx_wr      = !rw && io_hit && (addr[1:0] == 2'd1);
        tx_ready   = (tx_state_q == TX_IDLE);
        rx_s       = rx_sync_q[1];
        rx_latch   = 1'b0;

        io_sel_d   = io_hit;
        data_out_d = '0;
        if (rd_en) begin
            case (addr[1:0])
                2'd0:    data_out_d[0]   = tx_ready;
                2'd2:    data_out_d[1:0] = {overrun_q, rx_ready_q};
                2'd3:    data_out_d[7:0] = rx_data_q;
                default: data_out_d      = '0;
            endcase
        end

        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        if (tx_state_q == TX_IDLE) begin
            if (tx_wr) begin
                tx_state_d = TX_START;
                tx_cnt_d   = '0;
                tx_shift_d = data_in[7:0];
                tx_d       = 1'b0;
            end
        end else if (tx_cnt_q != CNT_LAST) begin
            tx_cnt_d = tx_cnt_q + 1'b1;
        end else begin
            tx_cnt_d = '0;
            case (tx_state_q)
                TX_START: begin
                    tx_state_d = TX_DATA;
                    tx_bit_d   = 3'd0;
                    tx_d       = tx_shift_q[0];
                end
                TX_DATA: begin
                    // Shift register keeps the bit currently on the line in [0].
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end
                default: tx_state_d = TX_IDLE;
            endcase
        end

        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                rx_cnt_d = rx_cnt_q + 1'b1;
                if (rx_cnt_q == CNT_HALF) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                rx_cnt_d = rx_cnt_q + 1'b1;
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                rx_cnt_d = rx_cnt_q + 1'b1;
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_latch   = rx_s;
                    rx_state_d = rx_s ? RX_IDLE : RX_WAIT;
                end
            end
            RX_WAIT: if (rx_s) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase

        // A byte landing on the same edge as a data read beats the read-clear.
        rx_data_d  = rx_data_q;
        rx_ready_d = rx_ready_q;
        overrun_d  = overrun_q;
        if (rx_latch) begin
            rx_data_d  = rx_shift_q;
            rx_ready_d = 1'b1;
            overrun_d  = overrun_q | rx_ready_q;
        end else if (rd_en && addr[1:0] == 2'd3) begin
            rx_ready_d = 1'b0;
            overrun_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            rx_sync_q  <= 2'b11;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_ready_q <= 1'b0;
            overrun_q  <= 1'b0;
            data_out_q <= '0;
            io_sel_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            rx_sync_q  <= {rx_sync_q[0], rx};
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_ready_q <= rx_ready_d;
            overrun_q  <= overrun_d;
            data_out_q <= data_out_d;
            io_sel_q   <= io_sel_d;
        end
    end

    assign data_out = data_out_q;
    assign io_sel   = io_sel_q;
    assign tx       = tx_q;

endmodule

// File: tb/tb_simplez_io.sv
// tb/tb_simplez_io.sv - directed bench for simplez_io with a cycle-level behavioural model
module tb_simplez_io;
    localparam int B = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  addr = '0;
    logic        rw = 1'b1;
    logic [11:0] data_in = '0;
    logic [11:0] data_out;
    logic        io_sel;
    logic        tx;
    logic        rx = 1'b1;

    always #5 clk = ~clk;

    simplez_io #(.BAUD_DIV(B), .AW(9), .DW(12)) dut (
        .clk(clk), .rst(rst), .addr(addr), .rw(rw), .data_in(data_in),
        .data_out(data_out), .io_sel(io_sel), .tx(tx), .rx(rx)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%03h want 0x%03h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a frame written at edge tx_k occupies edges tx_k .. tx_k+10*B-1.
    // Received bytes are queued with the edge on which they must appear.
    typedef struct {int edge_no; logic [7:0] b; bit ok;} rx_ev_t;
    rx_ev_t     rxq[$];
    int         tx_k = 0;
    int         tx_end = 0;
    logic [7:0] m_tx_byte = '0;
    bit         m_rdy = 0, m_ovr = 0;
    logic [7:0] m_rx_byte = '0;

    always @(posedge clk) begin : model
        int t, idx;
        logic [11:0] e_do;
        logic e_io, e_tx;
        bit latched;
        rx_ev_t ev;
        cyc++;
        t = cyc;
        e_do = '0; e_io = 1'b0; e_tx = 1'b1;
        if (rst) begin
            rxq.delete();
            tx_k = 0; tx_end = 0;
            m_rdy = 0; m_ovr = 0; m_rx_byte = '0;
        end else begin
            e_io = (addr >= 9'd508);
            if (rw) begin
                if (addr == 9'd508) e_do = (t - 1 >= tx_end) ? 12'd1 : 12'd0;
                if (addr == 9'd510) e_do = {10'd0, m_ovr, m_rdy};
                if (addr == 9'd511) e_do = {4'd0, m_rx_byte};
            end
            latched = 0;
            if (rxq.size() != 0 && rxq[0].edge_no == t) begin
                ev = rxq.pop_front();
                if (ev.ok) begin
                    m_ovr = m_ovr | m_rdy;
                    m_rdy = 1;
                    m_rx_byte = ev.b;
                    latched = 1;
                end
            end
            if (rw && addr == 9'd511 && !latched) begin
                m_rdy = 0; m_ovr = 0;
            end
            if (!rw && addr == 9'd509 && t - 1 >= tx_end) begin
                tx_k = t; tx_end = t + 10 * B; m_tx_byte = data_in[7:0];
            end
            if (t >= tx_k && t < tx_end) begin
                idx = (t - tx_k) / B;
                if (idx == 0) e_tx = 1'b0;
                else if (idx <= 8) e_tx = m_tx_byte[idx-1];
                else e_tx = 1'b1;
            end
        end
        #1;
        check("model_tx", tx, e_tx);
        check("model_io_sel", io_sel, e_io);
        check("model_data_out", data_out, e_do);
    end

    task automatic bus(input logic [8:0] a, input logic r, input logic [11:0] d);
        @(negedge clk);
        addr = a; rw = r; data_in = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(9'd0, 1'b1, 12'd0);
    endtask

    task automatic rd_chk(input string nm, input logic [8:0] a, input logic [11:0] exp);
        bus(a, 1'b1, 12'd0);
        @(posedge clk); #1;
        check(nm, data_out, exp);
        check({nm, "_sel"}, io_sel, {11'd0, (a >= 9'd508)});
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop_ok, input logic [8:0] post_addr);
        logic [9:0] frame;
        rx_ev_t ev;
        frame = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) begin
                addr = 9'd0; rw = 1'b1;
                ev.edge_no = cyc + 1 + 2 + B / 2 + 9 * B;
                ev.b = b; ev.ok = stop_ok;
                rxq.push_back(ev);
            end
            rx = frame[i];
            repeat (B - 1) @(negedge clk);
        end
        @(negedge clk);
        rx = 1'b1; addr = post_addr; rw = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [9:0] frame_a5;
        frame_a5 = {1'b1, 8'hA5, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", tx, 12'd1);
        check("reset_io_sel", io_sel, 12'd0);
        check("reset_data_out", data_out, 12'd0);
        @(negedge clk); rst = 1'b0;

        rd_chk("screen_status_idle", 9'd508, 12'h001);
        rd_chk("kbd_status_empty", 9'd510, 12'h000);
        rd_chk("addr_507", 9'd507, 12'h000);

        bus(9'd509, 1'b0, 12'h0A5);
        @(posedge clk); #1;
        check("tx_start_bit", tx, 12'd0);
        for (int j = 1; j <= 44; j++) begin
            if (j == 8) bus(9'd509, 1'b0, 12'h0FF);
            else bus(9'd508, 1'b1, 12'd0);
            @(posedge clk); #1;
            check("tx_frame_a5", tx, (j < 40) ? {11'd0, frame_a5[j/B]} : 12'd1);
            if (j == 20) check("tx_busy_status", data_out, 12'h000);
            if (j == 44) check("tx_done_status", data_out, 12'h001);
        end

        send_rx(8'h3C, 1'b1, 9'd0);
        idle(1);
        rd_chk("rx_3c_status", 9'd510, 12'h001);
        rd_chk("rx_3c_data", 9'd511, 12'h03C);
        rd_chk("rx_3c_cleared", 9'd510, 12'h000);

        send_rx(8'h11, 1'b1, 9'd0);
        send_rx(8'h22, 1'b1, 9'd0);
        idle(1);
        rd_chk("overrun_status", 9'd510, 12'h003);
        rd_chk("overrun_data", 9'd511, 12'h022);
        rd_chk("overrun_cleared", 9'd510, 12'h000);

        @(negedge clk); rx = 1'b0;
        @(negedge clk); rx = 1'b1;
        idle(10);
        rd_chk("glitch_no_byte", 9'd510, 12'h000);

        send_rx(8'h55, 1'b0, 9'd0);
        idle(4);
        rd_chk("framing_no_ready", 9'd510, 12'h000);
        send_rx(8'h7E, 1'b1, 9'd0);
        idle(1);
        rd_chk("recover_status", 9'd510, 12'h001);
        rd_chk("recover_data", 9'd511, 12'h07E);

        send_rx(8'h5A, 1'b1, 9'd511);
        @(posedge clk); #1;
        check("same_edge_old_byte", data_out, 12'h07E);
        rd_chk("same_edge_ready_kept", 9'd510, 12'h001);
        rd_chk("same_edge_new_byte", 9'd511, 12'h05A);
        rd_chk("same_edge_cleared", 9'd510, 12'h000);

        bus(9'd509, 1'b0, 12'h0F0);
        @(posedge clk); #1;
        for (int j = 1; j <= 15; j++) begin
            bus(9'd0, 1'b1, 12'd0);
            @(posedge clk); #1;
        end
        check("tx_before_reset", tx, 12'd0);
        #2 rst = 1'b1;
        #1 check("tx_async_reset", tx, 12'd1);
        @(negedge clk);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd_chk("status_after_reset", 9'd508, 12'h001);
        bus(9'd511, 1'b0, 12'h0FF);
        rd_chk("kbd_write_ignored", 9'd510, 12'h000);
        rd_chk("screen_still_idle", 9'd508, 12'h001);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
